// File: rtl/pipe_datapath.sv
// Three-stage pipelined execute/memory/writeback datapath.
//   EX : register read, operand forwarding, ALU (zero/alu_result exposed for branches)
//   MEM: synchronous byte-addressable data memory (stores on S2 exit, loads captured into S3)
//   WB : result select; register write on the edge ending the WB cycle
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   instruction handshake; in_ready drops one cycle on load-use
//   rs1, rs2, rd, imm_ext, pc_plus4, alu_src, alu_control, mem_we, reg_we,
//   result_src, addressing_control   decoded instruction fields
//   zero, alu_result    combinational EX ALU outputs
//   wb_valid/wb_rd/wb_data   retiring instruction (registered S3 contents)
//   test_reg_addr/test_reg_data  debug regfile read, no forwarding
module pipe_datapath #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned MEM_BYTES  = 1024,
  localparam int unsigned RAW       = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RAW-1:0]        rs1,
  input  logic [RAW-1:0]        rs2,
  input  logic [RAW-1:0]        rd,
  input  logic [DATA_WIDTH-1:0] imm_ext,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic                  alu_src,
  input  logic [3:0]            alu_control,
  input  logic                  mem_we,
  input  logic                  reg_we,
  input  logic [1:0]            result_src,
  input  logic [2:0]            addressing_control,
  output logic                  zero,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  wb_valid,
  output logic [RAW-1:0]        wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  input  logic [RAW-1:0]        test_reg_addr,
  output logic [DATA_WIDTH-1:0] test_reg_data
);
  localparam int unsigned WB   = DATA_WIDTH / 8;
  localparam int unsigned OFFW = $clog2(WB);
  localparam int unsigned MAW  = $clog2(MEM_BYTES);
  localparam int unsigned SHW  = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic [7:0]            r_mem  [MEM_BYTES];

  logic                  r_s2_valid, r_s2_reg_we, r_s2_mem_we;
  logic [RAW-1:0]        r_s2_rd;
  logic [1:0]            r_s2_result_src;
  logic [2:0]            r_s2_addr_ctrl;
  logic [DATA_WIDTH-1:0] r_s2_alu, r_s2_store, r_s2_pc4;

  logic                  r_s3_valid, r_s3_reg_we;
  logic [RAW-1:0]        r_s3_rd;
  logic [1:0]            r_s3_result_src;
  logic [2:0]            r_s3_addr_ctrl;
  logic [DATA_WIDTH-1:0] r_s3_alu, r_s3_pc4, r_s3_word;

  logic                  w_s2_fwd_ok, w_s3_fwd_ok, w_load_use, w_accept;
  logic [DATA_WIDTH-1:0] w_s2_fwd, w_s3_result, w_rs1_val, w_rs2_val, w_srcb, w_alu;
  logic [SHW-1:0]        w_shamt;
  logic [OFFW-1:0]       w_ld_off, w_ld_off_h, w_st_off;
  logic [DATA_WIDTH-1:0] w_ld_b, w_ld_h;
  logic [MAW-1:0]        w_base;
  logic [MAW-1:0]        w_idx       [WB];
  logic [7:0]            w_lane_data [WB];
  logic [WB-1:0]         w_lane_en;

  // ---------------- WB result select ----------------
  always_comb begin
    w_ld_off   = r_s3_alu[OFFW-1:0];
    w_ld_off_h = w_ld_off & ~OFFW'(1);
    w_ld_b     = r_s3_word >> {w_ld_off, 3'b000};
    w_ld_h     = r_s3_word >> {w_ld_off_h, 3'b000};
    w_s3_result = r_s3_alu;
    if (r_s3_result_src == 2'b01) begin
      case (r_s3_addr_ctrl)
        3'b000:  w_s3_result = {{(DATA_WIDTH-8){w_ld_b[7]}}, w_ld_b[7:0]};
        3'b001:  w_s3_result = {{(DATA_WIDTH-16){w_ld_h[15]}}, w_ld_h[15:0]};
        3'b100:  w_s3_result = {{(DATA_WIDTH-8){1'b0}}, w_ld_b[7:0]};
        3'b101:  w_s3_result = {{(DATA_WIDTH-16){1'b0}}, w_ld_h[15:0]};
        default: w_s3_result = r_s3_word;
      endcase
    end else if (r_s3_result_src == 2'b10) begin
      w_s3_result = r_s3_pc4;
    end
  end

  // ---------------- EX: forwarding, hazard, ALU ----------------
  // A load in S2 has no data yet, so it never forwards from S2; the stall covers it.
  assign w_s2_fwd_ok = r_s2_valid && r_s2_reg_we && (r_s2_rd != '0) && (r_s2_result_src != 2'b01);
  assign w_s3_fwd_ok = r_s3_valid && r_s3_reg_we && (r_s3_rd != '0);
  assign w_s2_fwd    = (r_s2_result_src == 2'b10) ? r_s2_pc4 : r_s2_alu;

  always_comb begin
    w_rs1_val = (rs1 == '0) ? '0 : r_regs[rs1];
    if (w_s2_fwd_ok && r_s2_rd == rs1)      w_rs1_val = w_s2_fwd;
    else if (w_s3_fwd_ok && r_s3_rd == rs1) w_rs1_val = w_s3_result;
    w_rs2_val = (rs2 == '0) ? '0 : r_regs[rs2];
    if (w_s2_fwd_ok && r_s2_rd == rs2)      w_rs2_val = w_s2_fwd;
    else if (w_s3_fwd_ok && r_s3_rd == rs2) w_rs2_val = w_s3_result;
  end

  assign w_load_use = r_s2_valid && r_s2_reg_we && (r_s2_result_src == 2'b01) &&
                      (r_s2_rd != '0) && (r_s2_rd == rs1 || r_s2_rd == rs2);
  assign in_ready   = !w_load_use;
  assign w_accept   = in_valid && in_ready;

  assign w_srcb  = alu_src ? imm_ext : w_rs2_val;
  assign w_shamt = w_srcb[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (alu_control)
      4'b0000: w_alu = w_rs1_val + w_srcb;
      4'b0001: w_alu = w_rs1_val - w_srcb;
      4'b0010: w_alu = w_rs1_val & w_srcb;
      4'b0011: w_alu = w_rs1_val | w_srcb;
      4'b0100: w_alu = w_rs1_val ^ w_srcb;
      4'b0101: w_alu = w_rs1_val << w_shamt;
      4'b0110: w_alu = w_rs1_val >> w_shamt;
      4'b0111: w_alu = $signed(w_rs1_val) >>> w_shamt;
      4'b1000: w_alu = {{(DATA_WIDTH-1){1'b0}}, $signed(w_rs1_val) < $signed(w_srcb)};
      4'b1001: w_alu = {{(DATA_WIDTH-1){1'b0}}, w_rs1_val < w_srcb};
      default: w_alu = '0;
    endcase
  end

  assign alu_result    = w_alu;
  assign zero          = (w_alu == '0);
  assign test_reg_data = r_regs[test_reg_addr];
  assign wb_valid      = r_s3_valid;
  assign wb_rd         = r_s3_rd;
  assign wb_data       = w_s3_result;

  // ---------------- MEM: byte lanes of the addressed word ----------------
  always_comb begin
    w_st_off = r_s2_alu[OFFW-1:0];
    w_base   = r_s2_alu[MAW-1:0] & ~MAW'(WB-1);
    for (int k = 0; k < WB; k++) begin
      w_idx[k] = w_base | MAW'(k);
      case (r_s2_addr_ctrl)
        3'b000, 3'b100: begin
          w_lane_en[k]   = (OFFW'(k) == w_st_off);
          w_lane_data[k] = r_s2_store[7:0];
        end
        3'b001, 3'b101: begin
          w_lane_en[k]   = ((OFFW'(k) & ~OFFW'(1)) == (w_st_off & ~OFFW'(1)));
          w_lane_data[k] = r_s2_store[(k % 2)*8 +: 8];
        end
        default: begin
          w_lane_en[k]   = 1'b1;
          w_lane_data[k] = r_s2_store[k*8 +: 8];
        end
      endcase
    end
  end

  // Memory is not reset; stores are suppressed in the reset cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WB; k++) begin
      if (!rst && r_s2_valid && r_s2_mem_we && w_lane_en[k]) r_mem[w_idx[k]] <= w_lane_data[k];
      r_s3_word[k*8 +: 8] <= r_mem[w_idx[k]];
    end
  end

  // ---------------- Pipeline registers and regfile ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0; r_s2_reg_we <= 1'b0; r_s2_mem_we <= 1'b0; r_s2_rd <= '0;
      r_s2_result_src <= '0; r_s2_addr_ctrl <= '0;
      r_s2_alu <= '0; r_s2_store <= '0; r_s2_pc4 <= '0;
      r_s3_valid <= 1'b0; r_s3_reg_we <= 1'b0; r_s3_rd <= '0;
      r_s3_result_src <= '0; r_s3_addr_ctrl <= '0; r_s3_alu <= '0; r_s3_pc4 <= '0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      r_s2_valid      <= w_accept;
      r_s2_reg_we     <= reg_we;
      r_s2_mem_we     <= mem_we;
      r_s2_rd         <= rd;
      r_s2_result_src <= result_src;
      r_s2_addr_ctrl  <= addressing_control;
      r_s2_alu        <= w_alu;
      r_s2_store      <= w_rs2_val;
      r_s2_pc4        <= pc_plus4;
      r_s3_valid      <= r_s2_valid;
      r_s3_reg_we     <= r_s2_reg_we;
      r_s3_rd         <= r_s2_rd;
      r_s3_result_src <= r_s2_result_src;
      r_s3_addr_ctrl  <= r_s2_addr_ctrl;
      r_s3_alu        <= r_s2_alu;
      r_s3_pc4        <= r_s2_pc4;
      if (r_s3_valid && r_s3_reg_we && r_s3_rd != '0) r_regs[r_s3_rd] <= w_s3_result;
    end
  end
endmodule

// File: tb/tb_pipe_datapath.sv
module tb_pipe_datapath;
  logic        clk, rst, in_valid, in_ready, alu_src, mem_we, reg_we, zero, wb_valid;
  logic [4:0]  rs1, rs2, rd, wb_rd, test_reg_addr;
  logic [31:0] imm_ext, pc_plus4, alu_result, wb_data, test_reg_data;
  logic [3:0]  alu_control;
  logic [1:0]  result_src;
  logic [2:0]  addressing_control;
  int checks = 0;
  int failures = 0;

  pipe_datapath dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm_ext(imm_ext), .pc_plus4(pc_plus4),
    .alu_src(alu_src), .alu_control(alu_control), .mem_we(mem_we), .reg_we(reg_we),
    .result_src(result_src), .addressing_control(addressing_control),
    .zero(zero), .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .test_reg_addr(test_reg_addr), .test_reg_data(test_reg_data)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic [31:0] imm, input logic src,
                       input logic [3:0] op, input logic mw, input logic rw,
                       input logic [1:0] rsel, input logic [2:0] ac);
    in_valid = v; rs1 = a1; rs2 = a2; rd = d; imm_ext = imm; alu_src = src;
    alu_control = op; mem_we = mw; reg_we = rw; result_src = rsel; addressing_control = ac;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 3'b010);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); tick();
    rst = 1'b0; test_reg_addr = 5'd1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b want 1", in_ready); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got %b want 0", wb_valid); end
    checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL rst_wb_rd got %0d want 0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL rst_wb_data got %h want 0", wb_data); end
    checks++; if (test_reg_data !== 32'd0) begin failures++; $display("FAIL rst_reg got %h want 0", test_reg_data); end
  endtask

  task automatic test_forward();
    drive(1, 0, 0, 1, 32'd5, 1, 4'b0000, 0, 1, 2'b00, 3'b010);  // ADDI x1 = 5
    checks++; if (alu_result !== 32'd5) begin failures++; $display("FAIL addi_alu got %h want 5", alu_result); end
    tick();
    drive(1, 1, 1, 2, 32'd0, 0, 4'b0000, 0, 1, 2'b00, 3'b010);  // ADD x2 = x1 + x1
    checks++; if (alu_result !== 32'd10) begin failures++; $display("FAIL s2_fwd got %h want a", alu_result); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fwd_nostall got %b want 1", in_ready); end
    tick();
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd1, 32'd5}) begin failures++; $display("FAIL wb_x1 got %b %0d %h want 1 1 5", wb_valid, wb_rd, wb_data); end
    pc_plus4 = 32'h100;
    drive(1, 0, 0, 19, 32'd0, 1, 4'b0000, 0, 1, 2'b10, 3'b010); // JAL x19
    tick();
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd2, 32'd10}) begin failures++; $display("FAIL wb_x2 got %b %0d %h want 1 2 a", wb_valid, wb_rd, wb_data); end
    drive(1, 19, 0, 20, 32'd0, 0, 4'b0000, 0, 1, 2'b00, 3'b010); // ADD x20 = x19 + x0
    checks++; if (alu_result !== 32'h100) begin failures++; $display("FAIL pc4_fwd got %h want 100", alu_result); end
    tick();
    checks++; if ({wb_rd, wb_data} !== {5'd19, 32'h100}) begin failures++; $display("FAIL wb_link got %0d %h want 19 100", wb_rd, wb_data); end
    idle(); tick();
    checks++; if ({wb_rd, wb_data} !== {5'd20, 32'h100}) begin failures++; $display("FAIL wb_x20 got %0d %h want 20 100", wb_rd, wb_data); end
    tick();
    test_reg_addr = 5'd2; #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got %b want 0", wb_valid); end
    checks++; if (test_reg_data !== 32'd10) begin failures++; $display("FAIL reg_x2 got %h want a", test_reg_data); end
  endtask

  task automatic test_load_use();
    drive(1, 0, 2, 0, 32'd8, 1, 4'b0000, 1, 0, 2'b00, 3'b010);  // SW x2, 8(x0)
    tick();
    drive(1, 0, 0, 3, 32'd8, 1, 4'b0000, 0, 1, 2'b01, 3'b010);  // LW x3, 8(x0)
    tick();
    drive(1, 3, 1, 4, 32'd0, 0, 4'b0000, 0, 1, 2'b00, 3'b010);  // ADD x4 = x3 + x1
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_stall got %b want 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_release got %b want 1", in_ready); end
    checks++; if (alu_result !== 32'd15) begin failures++; $display("FAIL lu_fwd got %h want f", alu_result); end
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd3, 32'd10}) begin failures++; $display("FAIL wb_lw got %b %0d %h want 1 3 a", wb_valid, wb_rd, wb_data); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got %b want 0", wb_valid); end
    idle(); tick();
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd4, 32'd15}) begin failures++; $display("FAIL wb_x4 got %b %0d %h want 1 4 f", wb_valid, wb_rd, wb_data); end
  endtask

  task automatic test_mem();
    drive(1, 0, 0, 12, 32'h1234, 1, 4'b0000, 0, 1, 2'b00, 3'b010); tick(); // x12 = 0x1234
    drive(1, 0, 0, 7, 32'h80, 1, 4'b0000, 0, 1, 2'b00, 3'b010);    tick(); // x7 = 0x80
    drive(1, 0, 12, 0, 32'd0, 1, 4'b0000, 1, 0, 2'b00, 3'b010);    tick(); // SW x12, 0
    drive(1, 0, 7, 0, 32'd3, 1, 4'b0000, 1, 0, 2'b00, 3'b000);     tick(); // SB x7, 3
    drive(1, 0, 0, 8, 32'd3, 1, 4'b0000, 0, 1, 2'b01, 3'b000);     tick(); // LB x8, 3
    drive(1, 0, 0, 9, 32'd3, 1, 4'b0000, 0, 1, 2'b01, 3'b100);     tick(); // LBU x9, 3
    checks++; if ({wb_rd, wb_data} !== {5'd8, 32'hFFFFFF80}) begin failures++; $display("FAIL lb got %0d %h want 8 ffffff80", wb_rd, wb_data); end
    drive(1, 0, 0, 10, 32'hBEEF, 1, 4'b0000, 0, 1, 2'b00, 3'b010); tick(); // x10 = 0xBEEF
    checks++; if ({wb_rd, wb_data} !== {5'd9, 32'h80}) begin failures++; $display("FAIL lbu got %0d %h want 9 80", wb_rd, wb_data); end
    drive(1, 0, 10, 0, 32'd2, 1, 4'b0000, 1, 0, 2'b00, 3'b001);    tick(); // SH x10, 2
    drive(1, 0, 0, 11, 32'd0, 1, 4'b0000, 0, 1, 2'b01, 3'b010);    tick(); // LW x11, 0
    idle(); tick();
    checks++; if ({wb_rd, wb_data} !== {5'd11, 32'hBEEF1234}) begin failures++; $display("FAIL sh_lw got %0d %h want 11 beef1234", wb_rd, wb_data); end
  endtask

  task automatic test_x0();
    drive(1, 0, 0, 0, 32'd7, 1, 4'b0000, 0, 1, 2'b00, 3'b010); tick(); // ADDI x0 = 7
    drive(1, 0, 0, 5, 32'd0, 0, 4'b0000, 0, 1, 2'b00, 3'b010);         // ADD x5 = x0 + x0
    checks++; if (alu_result !== 32'd0) begin failures++; $display("FAIL x0_nofwd got %h want 0", alu_result); end
    tick(); idle(); tick();
    test_reg_addr = 5'd0; #1;
    checks++; if ({wb_rd, wb_data} !== {5'd5, 32'd0}) begin failures++; $display("FAIL wb_x5 got %0d %h want 5 0", wb_rd, wb_data); end
    checks++; if (test_reg_data !== 32'd0) begin failures++; $display("FAIL reg_x0 got %h want 0", test_reg_data); end
  endtask

  task automatic test_alu();
    logic [3:0]  ops [8];
    logic [31:0] imms [8];
    logic [31:0] exps [8];
    ops  = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0000, 4'b1111, 4'b0101};
    imms = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd1, 32'hFFFFFFFA, 32'd3, 32'd33};
    exps = '{32'd1, 32'd7, 32'd6, 32'd40, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd10};
    drive(1, 1, 1, 6, 32'd0, 0, 4'b0001, 0, 1, 2'b00, 3'b010); // SUB x6 = x1 - x1
    checks++; if ({zero, alu_result} !== {1'b1, 32'd0}) begin failures++; $display("FAIL sub_zero got %b %h want 1 0", zero, alu_result); end
    tick();
    drive(1, 0, 0, 13, 32'h80000000, 1, 4'b0000, 0, 1, 2'b00, 3'b010); tick();
    drive(1, 13, 0, 14, 32'd31, 1, 4'b0111, 0, 1, 2'b00, 3'b010);      // SRA x14 = x13 >>> 31
    checks++; if (alu_result !== 32'hFFFFFFFF) begin failures++; $display("FAIL sra got %h want ffffffff", alu_result); end
    tick();
    drive(1, 0, 0, 15, 32'd1, 1, 4'b0000, 0, 1, 2'b00, 3'b010); tick(); // x15 = 1
    drive(1, 15, 14, 16, 32'd0, 0, 4'b1001, 0, 0, 2'b00, 3'b010);       // SLTU x15, x14
    checks++; if (alu_result !== 32'd1) begin failures++; $display("FAIL sltu got %h want 1", alu_result); end
    drive(1, 15, 14, 16, 32'd0, 0, 4'b1000, 0, 0, 2'b00, 3'b010);       // SLT x15, x14
    checks++; if ({zero, alu_result} !== {1'b1, 32'd0}) begin failures++; $display("FAIL slt got %b %h want 1 0", zero, alu_result); end
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 0, imms[i], 1, ops[i], 0, 0, 2'b00, 3'b010);
      checks++; if (alu_result !== exps[i]) begin failures++; $display("FAIL alu_op%0d got %h want %h", i, alu_result, exps[i]); end
    end
    idle(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 2, 0, 32'd16, 1, 4'b0000, 1, 0, 2'b00, 3'b010); tick(); // SW x2, 16
    idle(); tick(); tick();
    drive(1, 0, 0, 17, 32'd99, 1, 4'b0000, 0, 1, 2'b00, 3'b010); tick(); // x17 = 99
    drive(1, 0, 1, 0, 32'd16, 1, 4'b0000, 1, 0, 2'b00, 3'b010); tick();  // SW x1, 16
    rst = 1'b1; idle(); tick();
    rst = 1'b0; test_reg_addr = 5'd17; #1;
    checks++; if ({wb_valid, wb_data} !== {1'b0, 32'd0}) begin failures++; $display("FAIL mid_wb got %b %h want 0 0", wb_valid, wb_data); end
    checks++; if (test_reg_data !== 32'd0) begin failures++; $display("FAIL mid_x17 got %h want 0", test_reg_data); end
    test_reg_addr = 5'd1; #1;
    checks++; if (test_reg_data !== 32'd0) begin failures++; $display("FAIL mid_x1 got %h want 0", test_reg_data); end
    drive(1, 0, 0, 18, 32'd16, 1, 4'b0000, 0, 1, 2'b01, 3'b010); tick(); // LW x18, 16
    drive(1, 0, 0, 21, 32'd8, 1, 4'b0000, 0, 1, 2'b01, 3'b010); tick();  // LW x21, 8
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd18, 32'd10}) begin failures++; $display("FAIL mid_mem got %b %0d %h want 1 18 a", wb_valid, wb_rd, wb_data); end
    idle(); tick();
    checks++; if ({wb_rd, wb_data} !== {5'd21, 32'd10}) begin failures++; $display("FAIL mem8 got %0d %h want 21 a", wb_rd, wb_data); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst = 1'b1; pc_plus4 = 32'd0; test_reg_addr = 5'd0;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_mem();
    test_x0();
    test_alu();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
